// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported data memory between the CPU and EXT requesters.
// Optional access statistics are compiled in with `define ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_acc_cnt,
    output logic [15:0]       ext_acc_cnt
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_EXT} state_t;

    localparam int unsigned    BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic              last_ext_q, last_ext_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [RD_LAT:0]   rd_v_q, rd_ext_q;
    logic [DATA_W-1:0] cpu_hold_q, ext_hold_q;

    logic              own_ext, own_req, oth_req;
    logic              cpu_acc, ext_acc, acc, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign cpu_gnt   = (state_q == OWN_CPU);
    assign ext_gnt   = (state_q == OWN_EXT);
    assign cpu_acc   = cpu_req & cpu_gnt;
    assign ext_acc   = ext_req & ext_gnt;
    assign acc       = cpu_acc | ext_acc;
    assign acc_we    = ext_acc ? ext_we    : cpu_we;
    assign acc_addr  = ext_acc ? ext_addr  : cpu_addr;
    assign acc_wdata = ext_acc ? ext_wdata : cpu_wdata;

    always_comb begin
        own_ext    = (state_q == OWN_EXT);
        own_req    = own_ext ? ext_req : cpu_req;
        oth_req    = own_ext ? cpu_req : ext_req;
        state_d    = state_q;
        burst_d    = burst_q;
        last_ext_d = last_ext_q;
        case (state_q)
            IDLE: begin
                if (cpu_req && ext_req) state_d = last_ext_q ? OWN_CPU : OWN_EXT;
                else if (cpu_req)       state_d = OWN_CPU;
                else if (ext_req)       state_d = OWN_EXT;
            end
            OWN_CPU, OWN_EXT: begin
                // Keep the bus unless the owner went quiet or used its last burst slot with the other port waiting.
                if (own_req && !(oth_req && burst_q == BURST_LAST)) begin
                    if (burst_q != BURST_LAST) burst_d = burst_q + 1'b1;
                end else begin
                    state_d    = oth_req ? (own_ext ? OWN_CPU : OWN_EXT) : IDLE;
                    burst_d    = '0;
                    last_ext_d = own_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_ext_q  <= 1'b1;
            burst_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_v_q      <= '0;
            rd_ext_q    <= '0;
            cpu_hold_q  <= '0;
            ext_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_ext_q <= last_ext_d;
            burst_q    <= burst_d;
            mem_en_q   <= acc;
            mem_we_q   <= acc & acc_we;
            if (acc) begin
                mem_addr_q  <= acc_addr;
                mem_wdata_q <= acc_wdata;
            end
            // Stage 0 coincides with mem_en; stage RD_LAT is the cycle mem_rdata is valid.
            rd_v_q   <= {rd_v_q[RD_LAT-1:0],   acc & ~acc_we};
            rd_ext_q <= {rd_ext_q[RD_LAT-1:0], ext_acc};
            if (cpu_rvalid) cpu_hold_q <= mem_rdata;
            if (ext_rvalid) ext_hold_q <= mem_rdata;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rvalid = rd_v_q[RD_LAT] & ~rd_ext_q[RD_LAT];
    assign ext_rvalid = rd_v_q[RD_LAT] &  rd_ext_q[RD_LAT];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
    assign ext_rdata  = ext_rvalid ? mem_rdata : ext_hold_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_cnt_q, ext_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_cnt_q <= '0;
            ext_cnt_q <= '0;
        end else begin
            if (cpu_acc && cpu_cnt_q != '1) cpu_cnt_q <= cpu_cnt_q + 16'd1;
            if (ext_acc && ext_cnt_q != '1) ext_cnt_q <= ext_cnt_q + 16'd1;
        end
    end

    assign cpu_acc_cnt = cpu_cnt_q;
    assign ext_acc_cnt = ext_cnt_q;
`else
    assign cpu_acc_cnt = '0;
    assign ext_acc_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle synchronous memory model.
module tb_mem_port_arbiter;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
    logic [15:0] cpu_rdata, ext_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] cpu_acc_cnt, ext_acc_cnt;

    int unsigned total = 0, bad = 0, cyc = 0;

    typedef struct {
        logic        ext;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int unsigned cyc;
    } ent_t;

    ent_t        memq[$], rdq[$];
    bit          acc_log[$];
    int unsigned acc_cyc[$];

    logic [15:0] mem    [0:65535];
    logic [15:0] shadow [0:65535];
    logic [15:0] mrd = '0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_acc_cnt(cpu_acc_cnt), .ext_acc_cnt(ext_acc_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mrd;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mrd <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge rst) begin
        memq.delete();
        rdq.delete();
    end

    // Monitor: retire memory-side and read-return events, then log new acceptances.
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            check("gnt_excl", {31'd0, cpu_gnt & ext_gnt}, 0);
            if (mem_en) begin
                if (memq.size() == 0) check("mem_spurious", {31'd0, mem_en}, 0);
                else begin
                    e = memq.pop_front();
                    check("mem_lat", cyc, e.cyc + 1);
                    check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    if (e.we) begin
                        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
                        shadow[e.addr] = e.data;
                    end
                end
            end else check("mem_we_idle", {31'd0, mem_we}, 0);
            check("rvalid_both", {31'd0, cpu_rvalid & ext_rvalid}, 0);
            if (cpu_rvalid || ext_rvalid) begin
                if (rdq.size() == 0) check("rvalid_spurious", {30'd0, cpu_rvalid, ext_rvalid}, 0);
                else begin
                    e = rdq.pop_front();
                    check("rd_port", {31'd0, ext_rvalid}, {31'd0, e.ext});
                    check("rd_lat", cyc, e.cyc + 1 + RD_LAT);
                    check("rd_data", {16'd0, (ext_rvalid ? ext_rdata : cpu_rdata)}, {16'd0, e.data});
                end
            end
            if (cpu_req && cpu_gnt) begin
                e = '{1'b0, cpu_we, cpu_addr, (cpu_we ? cpu_wdata : shadow[cpu_addr]), cyc};
                memq.push_back(e);
                if (!cpu_we) rdq.push_back(e);
                acc_log.push_back(1'b0);
                acc_cyc.push_back(cyc);
            end
            if (ext_req && ext_gnt) begin
                e = '{1'b1, ext_we, ext_addr, (ext_we ? ext_wdata : shadow[ext_addr]), cyc};
                memq.push_back(e);
                if (!ext_we) rdq.push_back(e);
                acc_log.push_back(1'b1);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic cpu_do(input logic we, input logic [15:0] a, input logic [15:0] d);
        int unsigned n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        while (!cpu_gnt && n < 200) begin n++; @(negedge clk); end
        check("cpu_gnt_wait", {31'd0, cpu_gnt}, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic ext_do(input logic we, input logic [15:0] a, input logic [15:0] d);
        int unsigned n = 0;
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        @(negedge clk);
        while (!ext_gnt && n < 200) begin n++; @(negedge clk); end
        check("ext_gnt_wait", {31'd0, ext_gnt}, 1);
        @(posedge clk); #1;
        ext_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        mem[16'h0010]    = 16'hBEEF;
        shadow[16'h0010] = 16'hBEEF;

        do_reset();

        // Asynchronous reset in the middle of live traffic
        cpu_do(1'b1, 16'h0030, 16'h5A5A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        repeat (4) @(negedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rst_gnt", {30'd0, cpu_gnt, ext_gnt}, 0);
        check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 0);
        check("rst_mem_addr", {16'd0, mem_addr}, 0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 0);
        check("rst_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, 0);
        check("rst_rdata", {cpu_rdata, ext_rdata}, 0);
        check("rst_cnt", {cpu_acc_cnt, ext_acc_cnt}, 0);
        cpu_req = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_gnt", {30'd0, cpu_gnt, ext_gnt}, 0);
        end

        // CPU read of 0x0010 with cycle-exact timing
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk); check("gnt_c0", {31'd0, cpu_gnt}, 0);
        @(negedge clk); check("gnt_c1", {31'd0, cpu_gnt}, 1);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        check("c2_mem", {14'd0, mem_en, mem_we, mem_addr}, {14'd0, 2'b10, 16'h0010});
        @(negedge clk);
        check("c3_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, {30'd0, 2'b10});
        check("c3_rdata", {16'd0, cpu_rdata}, {16'd0, 16'hBEEF});
        drain();
        check("rdata_hold", {16'd0, cpu_rdata}, {16'd0, 16'hBEEF});

        // EXT write then CPU read-back
        ext_do(1'b1, 16'h00FF, 16'h1234);
        drain();
        cpu_do(1'b0, 16'h00FF, 16'h0000);
        drain();
        check("readback", {16'd0, cpu_rdata}, {16'd0, 16'h1234});

        // Interleaved reads from both ports
        fork
            for (int i = 0; i < 4; i++) cpu_do(1'b0, 16'h0100 + 16'(i), 16'h0000);
            for (int i = 0; i < 4; i++) ext_do(1'b0, 16'h0200 + 16'(i), 16'h0000);
        join
        drain();

        // Read killed by reset before its data returns
        cpu_do(1'b0, 16'h0040, 16'h0000);
        #1 rst = 1'b1;
        #1 check("kill_mem_en", {31'd0, mem_en}, 0);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("kill_no_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, 0);
            check("kill_idle", {30'd0, cpu_gnt, ext_gnt}, 0);
        end

        // Both ports contending from reset: bounded bursts, no gaps
        do_reset();
        acc_log.delete();
        acc_cyc.delete();
        fork
            for (int i = 0; i < 12; i++) cpu_do(1'b1, 16'h0300 + 16'(i), 16'h2000 + 16'(i));
            for (int i = 0; i < 8; i++)  ext_do(1'b1, 16'h0400 + 16'(i), 16'h1000 + 16'(i));
        join
        drain();
        check("burst_len", acc_log.size(), 20);
        if (acc_log.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                check("burst_owner", {31'd0, acc_log[i]}, {31'd0, (i >= 8 && i < 16)});
                check("burst_nogap", acc_cyc[i], acc_cyc[0] + i);
            end
        end

        // Access statistics
        do_reset();
        for (int i = 0; i < 5; i++) cpu_do(1'b0, 16'h0500 + 16'(i), 16'h0000);
        for (int i = 0; i < 3; i++) ext_do(1'b1, 16'h0600 + 16'(i), 16'h3000 + 16'(i));
        drain();
`ifdef ARB_STATS_EN
        check("cpu_acc_cnt", {16'd0, cpu_acc_cnt}, 5);
        check("ext_acc_cnt", {16'd0, ext_acc_cnt}, 3);
`else
        check("cpu_acc_cnt", {16'd0, cpu_acc_cnt}, 0);
        check("ext_acc_cnt", {16'd0, ext_acc_cnt}, 0);
`endif

        check("memq_empty", memq.size(), 0);
        check("rdq_empty", rdq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
